// File: rtl/prog_loader.sv
// Program-image loader: streams a length-prefixed, checksummed byte image from
// the host link into the program RAM write port while holding the CPU in reset.
module prog_loader #(
    parameter int unsigned       ADDR_W     = 12,
    parameter int unsigned       DATA_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int unsigned HI_W  = 4;
    localparam int unsigned LEN_W = DATA_W + HI_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_ERROR
    } state_e;

    state_e state_q, state_d;

    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [HI_W-1:0]   len_hi_q, len_hi_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] sum_q, sum_d;

    logic              accept_c;
    logic              hi_bad_c;
    logic              csum_ok_c;
    logic [LEN_W-1:0]  len_full_c;

    assign accept_c   = in_valid_i && in_ready_q;
    assign hi_bad_c   = (in_data_i[DATA_W-1:HI_W] != '0);
    assign csum_ok_c  = (DATA_W'(sum_q + in_data_i) == '0);
    assign len_full_c = {len_hi_q, in_data_i};

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start_i) state_d = S_LEN_HI;
            S_LEN_HI: if (accept_c) state_d = hi_bad_c ? S_ERROR : S_LEN_LO;
            S_LEN_LO: if (accept_c) state_d = (len_full_c == '0) ? S_CSUM : S_DATA;
            S_DATA:   if (accept_c && count_q == LEN_W'(1)) state_d = S_CSUM;
            S_CSUM:   if (accept_c) state_d = csum_ok_c ? S_IDLE : S_ERROR;
            S_ERROR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; in_ready/busy track the upcoming state
    always_comb begin
        in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DATA)   || (state_d == S_CSUM);
        busy_d     = (state_d != S_IDLE);
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        error_d    = error_q;
        addr_d     = addr_q;
        len_hi_d   = len_hi_q;
        count_d    = count_q;
        sum_d      = sum_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    sum_d      = '0;
                    addr_d     = START_ADDR;
                end
            end
            S_LEN_HI: begin
                if (accept_c && !hi_bad_c) len_hi_d = in_data_i[HI_W-1:0];
            end
            S_LEN_LO: begin
                if (accept_c) count_d = len_full_c;
            end
            S_DATA: begin
                if (accept_c) begin
                    we_d    = 1'b1;
                    wdata_d = in_data_i;
                    waddr_d = addr_q;
                    addr_d  = ADDR_W'(addr_q + 1'b1);
                    sum_d   = DATA_W'(sum_q + in_data_i);
                    count_d = LEN_W'(count_q - 1'b1);
                end
            end
            S_CSUM: begin
                if (accept_c && csum_ok_c) begin
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (state_d == S_ERROR) error_d = 1'b1;
    end

    // Output and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= START_ADDR;
            wdata_q    <= '0;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            addr_q     <= START_ADDR;
            len_hi_q   <= '0;
            count_q    <= '0;
            sum_q      <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            addr_q     <= addr_d;
            len_hi_q   <= len_hi_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
        end
    end

    assign in_ready_o = in_ready_q;
    assign we_o       = we_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = wdata_q;
    assign cpu_hold_o = cpu_hold_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 000 and FFE) fed the same host
// stream, checked against a list-based image model.
module tb_prog_loader;

    logic clk = 1'b0;
    bit   clk_run = 1'b1;
    always #5 if (clk_run) clk = ~clk;

    logic        rst_ni;
    logic        start_i;
    logic        in_valid_i;
    logic [7:0]  in_data_i;

    logic        rdy0, we0, hold0, busy0, done0, err0;
    logic [11:0] waddr0;
    logic [7:0]  wdata0;
    logic        rdy1, we1, hold1, busy1, done1, err1;
    logic [11:0] waddr1;
    logic [7:0]  wdata1;

    prog_loader #(.ADDR_W(12), .DATA_W(8), .START_ADDR(12'h000)) dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(rdy0),
        .we_o(we0), .waddr_o(waddr0), .wdata_o(wdata0), .cpu_hold_o(hold0),
        .busy_o(busy0), .done_o(done0), .error_o(err0)
    );

    prog_loader #(.ADDR_W(12), .DATA_W(8), .START_ADDR(12'hFFE)) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(rdy1),
        .we_o(we1), .waddr_o(waddr1), .wdata_o(wdata1), .cpu_hold_o(hold1),
        .busy_o(busy1), .done_o(done1), .error_o(err1)
    );

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;

    logic [11:0] w0_addr[$];
    logic [7:0]  w0_data[$];
    int          w0_cyc[$];
    logic [11:0] w1_addr[$];
    logic [7:0]  w1_data[$];

    logic [7:0]  img[$];
    logic [7:0]  exp_data[$];
    bit          exp_done, exp_err;
    int          consumed;
    logic [2:0]  post_start;

    always @(posedge clk) cyc++;

    // RAM-write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_ni === 1'b1) begin
            if (we0 === 1'b1) begin
                w0_addr.push_back(waddr0);
                w0_data.push_back(wdata0);
                w0_cyc.push_back(cyc);
            end
            if (we1 === 1'b1) begin
                w1_addr.push_back(waddr1);
                w1_data.push_back(wdata1);
            end
        end
    end

    // Image model: which bytes the loader consumes, what it writes, final verdict
    task automatic model_image();
        logic [7:0] hi;
        int len, sum;
        exp_data.delete();
        hi = img[0];
        if (hi[7:4] != 4'h0) begin
            exp_err = 1'b1; exp_done = 1'b0; consumed = 1;
            return;
        end
        len = int'(hi[3:0]) * 256 + int'(img[1]);
        sum = 0;
        for (int i = 0; i < len; i++) begin
            exp_data.push_back(img[2 + i]);
            sum += int'(img[2 + i]);
        end
        consumed = len + 3;
        exp_done = ((sum + int'(img[2 + len])) % 256) == 0;
        exp_err  = !exp_done;
    endtask

    function automatic int sb_errs();
        int e = 0;
        if (w0_data.size() != exp_data.size()) e++;
        else for (int i = 0; i < exp_data.size(); i++)
            if (w0_data[i] !== exp_data[i] || w0_addr[i] !== 12'(i % 4096)) e++;
        if (w1_data.size() != exp_data.size()) e++;
        else for (int i = 0; i < exp_data.size(); i++)
            if (w1_data[i] !== exp_data[i] || w1_addr[i] !== 12'((4094 + i) % 4096)) e++;
        return e;
    endfunction

    function automatic logic [9:0] status();
        return {done0, err0, hold0, busy0, rdy0, done1, err1, hold1, busy1, rdy1};
    endfunction

    function automatic logic [9:0] exp_status();
        return {exp_done, exp_err, exp_err, 2'b00, exp_done, exp_err, exp_err, 2'b00};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive_image(input int gmin, input int gmax, input bit noise, input int limit);
        int n, g, tries;
        w0_addr.delete(); w0_data.delete(); w0_cyc.delete();
        w1_addr.delete(); w1_data.delete();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        post_start = {err0, hold0, busy0};
        n = (consumed < limit) ? consumed : limit;
        for (int i = 0; i < n; i++) begin
            g = (i == 0) ? 0 : int'($urandom_range(gmax, gmin));
            in_valid_i = 1'b0;
            repeat (g) tick();
            in_valid_i = 1'b1;
            in_data_i  = img[i];
            if (noise && $urandom_range(3, 0) == 0) start_i = 1'b1;
            tries = 0;
            while (rdy0 !== 1'b1 && tries < 20) begin
                tick();
                start_i = 1'b0;
                tries++;
            end
            if (tries == 20) begin
                nchk++; nfail++;
                $display("FAIL byte_accept: in_ready got 0 expected 1 for byte %0d", i);
                in_valid_i = 1'b0;
                return;
            end
            tick();
            start_i = 1'b0;
        end
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [25:0] got, exp;
        rst_ni = 1'b1; #1 rst_ni = 1'b0; #1;
        got = {rdy0, we0, hold0, busy0, done0, err0, wdata0, waddr0};
        exp = {6'b0, 8'h00, 12'h000};
        nchk++;
        if (got !== exp) begin nfail++; $display("FAIL reset_init0: got %h expected %h", got, exp); end
        got = {rdy1, we1, hold1, busy1, done1, err1, wdata1, waddr1};
        exp = {6'b0, 8'h00, 12'hFFE};
        nchk++;
        if (got !== exp) begin nfail++; $display("FAIL reset_init1: got %h expected %h", got, exp); end
        repeat (2) @(posedge clk);
        rst_ni = 1'b1;
        tick();

        img = '{8'h00, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00};
        model_image();
        in_valid_i = 1'b1;
        drive_image(0, 0, 1'b0, 4);
        nchk++;
        if ({we0, we1, busy0} !== 3'b111) begin
            nfail++; $display("FAIL reset_pre_we: we0/we1/busy got %b expected 111", {we0, we1, busy0});
        end
        @(negedge clk);
        clk_run = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        got = {rdy0, we0, hold0, busy0, done0, err0, wdata0, waddr0};
        exp = {6'b0, 8'h00, 12'h000};
        nchk++;
        if (got !== exp) begin nfail++; $display("FAIL reset_async0: got %h expected %h", got, exp); end
        got = {rdy1, we1, hold1, busy1, done1, err1, wdata1, waddr1};
        exp = {6'b0, 8'h00, 12'hFFE};
        nchk++;
        if (got !== exp) begin nfail++; $display("FAIL reset_async1: got %h expected %h", got, exp); end
        #2 rst_ni = 1'b1;
        clk_run = 1'b1;
        repeat (3) tick();
        nchk++;
        if ({busy0, hold0, busy1, hold1, we0} !== 5'b0) begin
            nfail++; $display("FAIL reset_release: busy/hold/we got %b expected 00000", {busy0, hold0, busy1, hold1, we0});
        end
    endtask

    task automatic test_basic();
        int e;
        img = '{8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hEA};
        model_image();
        drive_image(0, 0, 1'b0, 1000);
        repeat (3) tick();
        e = sb_errs();
        nchk++;
        if (e !== 0) begin nfail++; $display("FAIL basic_writes: %0d write mismatches, expected 0", e); end
        nchk++;
        if (w0_cyc.size() != 3 || w0_cyc[1] - w0_cyc[0] != 1 || w0_cyc[2] - w0_cyc[1] != 1) begin
            nfail++; $display("FAIL basic_b2b: %0d writes not on consecutive cycles, expected 3 consecutive", w0_cyc.size());
        end
        nchk++;
        if (status() !== exp_status()) begin
            nfail++; $display("FAIL basic_status: got %b expected %b", status(), exp_status());
        end
    endtask

    task automatic test_bad_csum();
        int e;
        img = '{8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hEB};
        model_image();
        drive_image(0, 0, 1'b0, 1000);
        repeat (3) tick();
        e = sb_errs();
        nchk++;
        if (e !== 0) begin nfail++; $display("FAIL badcsum_writes: %0d write mismatches, expected 0", e); end
        nchk++;
        if (status() !== exp_status()) begin
            nfail++; $display("FAIL badcsum_status: got %b expected %b", status(), exp_status());
        end
        repeat (6) tick();
        nchk++;
        if ({err0, hold0, done0, err1, hold1} !== 5'b11011) begin
            nfail++; $display("FAIL badcsum_hold: err/hold/done got %b expected 11011", {err0, hold0, done0, err1, hold1});
        end
    endtask

    task automatic test_bad_header();
        int e;
        img = '{8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
        model_image();
        drive_image(0, 0, 1'b0, 1000);
        nchk++;
        if (post_start !== 3'b011) begin
            nfail++; $display("FAIL start_clears: err/hold/busy got %b expected 011", post_start);
        end
        repeat (3) tick();
        e = sb_errs();
        nchk++;
        if (e !== 0 || w0_data.size() != 0) begin
            nfail++; $display("FAIL badhdr_nowrite: %0d writes, expected 0", w0_data.size());
        end
        nchk++;
        if (status() !== exp_status()) begin
            nfail++; $display("FAIL badhdr_status: got %b expected %b", status(), exp_status());
        end
    endtask

    task automatic test_gaps();
        int e;
        img = '{8'h00, 8'h03, 8'h5A, 8'h6B, 8'h7C, 8'h00};
        img[5] = 8'(256 - ((8'h5A + 8'h6B + 8'h7C) % 256));
        model_image();
        drive_image(2, 2, 1'b0, 1000);
        repeat (3) tick();
        e = sb_errs();
        nchk++;
        if (e !== 0) begin nfail++; $display("FAIL gaps_writes: %0d write mismatches, expected 0", e); end
        nchk++;
        if (w0_cyc.size() != 3 || w0_cyc[1] - w0_cyc[0] != 3) begin
            nfail++; $display("FAIL gaps_spacing: %0d writes, expected 3 spaced 3 cycles apart", w0_cyc.size());
        end
        nchk++;
        if (status() !== exp_status()) begin
            nfail++; $display("FAIL gaps_status: got %b expected %b", status(), exp_status());
        end
    endtask

    task automatic test_wrap();
        int e;
        img = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
        model_image();
        drive_image(0, 0, 1'b0, 1000);
        repeat (3) tick();
        e = sb_errs();
        nchk++;
        if (e !== 0 || w1_addr.size() != 3 || w1_addr[2] !== 12'h000) begin
            nfail++; $display("FAIL wrap_writes: %0d mismatches, expected writes at FFE FFF 000", e);
        end
        nchk++;
        if (status() !== exp_status()) begin
            nfail++; $display("FAIL wrap_status: got %b expected %b", status(), exp_status());
        end
        img = '{8'h00, 8'h00, 8'h00};
        model_image();
        drive_image(0, 0, 1'b0, 1000);
        repeat (3) tick();
        nchk++;
        if (w0_data.size() != 0 || w1_data.size() != 0) begin
            nfail++; $display("FAIL len0_nowrite: %0d writes, expected 0", w0_data.size() + w1_data.size());
        end
        nchk++;
        if (status() !== exp_status()) begin
            nfail++; $display("FAIL len0_status: got %b expected %b", status(), exp_status());
        end
    endtask

    task automatic test_random();
        int e, len, sum;
        for (int it = 0; it < 25; it++) begin
            len = int'($urandom_range(24, 0));
            img.delete();
            img.push_back(($urandom_range(9, 0) == 0) ? 8'(16 + $urandom_range(200, 0)) : 8'h00);
            img.push_back(8'(len));
            sum = 0;
            for (int i = 0; i < len; i++) begin
                img.push_back(8'($urandom));
                sum += int'(img[2 + i]);
            end
            img.push_back(($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'((256 - (sum % 256)) % 256));
            model_image();
            drive_image(0, 2, 1'b1, 1000);
            repeat (3) tick();
            e = sb_errs();
            nchk++;
            if (e !== 0) begin nfail++; $display("FAIL random%0d_writes: %0d write mismatches, expected 0", it, e); end
            nchk++;
            if (status() !== exp_status()) begin
                nfail++; $display("FAIL random%0d_status: got %b expected %b", it, status(), exp_status());
            end
        end
    endtask

    initial begin
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = 8'h00;
        test_reset();
        test_basic();
        test_bad_csum();
        test_bad_header();
        test_gaps();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
